// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: scans a double-buffered 16x16 frame onto a row-multiplexed LED panel
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   matrix      256-bit frame, bit y*16+x = row y column x; sampled in LOAD only
//   brightness  3-bit duty (7 = full); present only with LED_BRIGHTNESS_EN defined
//   ser_data    column bit to the external shift register
//   ser_clk     shift clock, register samples on its rising edge
//   ser_latch   one-cycle pulse moving the shifted row into the column drivers
//   oe_n        active-low panel enable, 1 = blanked
//   row_addr    selected row
//   frame_done  one-cycle pulse coinciding with the LOAD after row 15
//
// Optional feature macro: LED_BRIGHTNESS_EN
module led_matrix_scanner #(
    parameter int CLK_DIV     = 2,
    parameter int HOLD_CYCLES = 512
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] matrix,
`ifdef LED_BRIGHTNESS_EN
    input  logic [2:0]   brightness,
`endif
    output logic         ser_data,
    output logic         ser_clk,
    output logic         ser_latch,
    output logic         oe_n,
    output logic [3:0]   row_addr,
    output logic         frame_done
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {LOAD, SHIFT, LATCH, DISPLAY} state_t;

    state_t         state, state_nx;
    logic [255:0]   shadow, shadow_nx;
    logic [3:0]     row, row_nx, x, x_nx, row_addr_nx;
    logic [DW-1:0]  div, div_nx;
    logic           ph, ph_nx;
    logic [HW-1:0]  hold, hold_nx;
    logic           ser_data_nx, ser_clk_nx, ser_latch_nx, oe_n_nx, frame_done_nx;
`ifdef LED_BRIGHTNESS_EN
    logic [2:0]     bright, bright_nx;
    logic [HW+3:0]  on_len;
    // Lit portion of DISPLAY; never zero because HOLD_CYCLES >= 8.
    assign on_len = (HW+4)'(((32'(bright) + 32'd1) * 32'(HOLD_CYCLES)) >> 3);
`endif

    // All outputs are computed one cycle ahead and registered, so each output
    // lines up with the state it belongs to and nothing reaches a pin combinationally.
    always_comb begin
        state_nx      = state;
        shadow_nx     = shadow;
        row_nx        = row;
        x_nx          = x;
        div_nx        = div;
        ph_nx         = ph;
        hold_nx       = hold;
        ser_data_nx   = ser_data;
        ser_clk_nx    = ser_clk;
        ser_latch_nx  = 1'b0;
        oe_n_nx       = oe_n;
        row_addr_nx   = row_addr;
        frame_done_nx = 1'b0;
`ifdef LED_BRIGHTNESS_EN
        bright_nx     = bright;
`endif
        case (state)
            LOAD: begin
                state_nx    = SHIFT;
                shadow_nx   = matrix;
                row_nx      = 4'd0;
                x_nx        = 4'd15;
                div_nx      = '0;
                ph_nx       = 1'b0;
                ser_data_nx = matrix[15];
                ser_clk_nx  = 1'b0;
                oe_n_nx     = 1'b1;
`ifdef LED_BRIGHTNESS_EN
                bright_nx   = brightness;
`endif
            end
            SHIFT: begin
                div_nx = div + 1'b1;
                if (div == DIV_MAX) begin
                    div_nx     = '0;
                    ph_nx      = ~ph;
                    ser_clk_nx = ~ph;
                    if (ph) begin
                        if (x == 4'd0) begin
                            state_nx     = LATCH;
                            ser_latch_nx = 1'b1;
                            row_addr_nx  = row;
                        end else begin
                            x_nx        = x - 4'd1;
                            ser_data_nx = shadow[{row, x - 4'd1}];
                        end
                    end
                end
            end
            LATCH: begin
                state_nx = DISPLAY;
                hold_nx  = '0;
                oe_n_nx  = 1'b0;
            end
            DISPLAY: begin
                hold_nx = hold + 1'b1;
`ifdef LED_BRIGHTNESS_EN
                oe_n_nx = ((HW+4)'(hold) + (HW+4)'(1)) >= on_len;
`endif
                if (hold == HOLD_MAX) begin
                    oe_n_nx = 1'b1;
                    hold_nx = '0;
                    if (row == 4'd15) begin
                        state_nx      = LOAD;
                        frame_done_nx = 1'b1;
                    end else begin
                        state_nx    = SHIFT;
                        row_nx      = row + 4'd1;
                        x_nx        = 4'd15;
                        div_nx      = '0;
                        ph_nx       = 1'b0;
                        ser_data_nx = shadow[{row + 4'd1, 4'd15}];
                    end
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= LOAD;
            shadow     <= '0;
            row        <= 4'd0;
            x          <= 4'd15;
            div        <= '0;
            ph         <= 1'b0;
            hold       <= '0;
            ser_data   <= 1'b0;
            ser_clk    <= 1'b0;
            ser_latch  <= 1'b0;
            oe_n       <= 1'b1;
            row_addr   <= 4'd0;
            frame_done <= 1'b0;
`ifdef LED_BRIGHTNESS_EN
            bright     <= 3'd7;
`endif
        end else begin
            state      <= state_nx;
            shadow     <= shadow_nx;
            row        <= row_nx;
            x          <= x_nx;
            div        <= div_nx;
            ph         <= ph_nx;
            hold       <= hold_nx;
            ser_data   <= ser_data_nx;
            ser_clk    <= ser_clk_nx;
            ser_latch  <= ser_latch_nx;
            oe_n       <= oe_n_nx;
            row_addr   <= row_addr_nx;
            frame_done <= frame_done_nx;
`ifdef LED_BRIGHTNESS_EN
            bright     <= bright_nx;
`endif
        end
    end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: directed frame vectors plus tear, reset-abort and restart sequences
module tb_led_matrix_scanner;
    localparam int FRAME = 9233;
`ifdef LED_BRIGHTNESS_EN
    localparam int OE_EXP = 16 * 256;
`else
    localparam int OE_EXP = 16 * 512;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [255:0] matrix = '0;
    logic         ser_data, ser_clk, ser_latch, oe_n, frame_done;
    logic [3:0]   row_addr;
`ifdef LED_BRIGHTNESS_EN
    logic [2:0]   brightness = 3'd3;
`endif

    led_matrix_scanner dut (
        .clk(clk),
        .reset(reset),
        .matrix(matrix),
`ifdef LED_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .ser_data(ser_data),
        .ser_clk(ser_clk),
        .ser_latch(ser_latch),
        .oe_n(oe_n),
        .row_addr(row_addr),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Panel-side observer: emulates the external shift register and tallies activity.
    logic [15:0] sr = '0;
    logic [15:0] rows [16];
    logic        pclk = 1'b0;
    int ones_tot = 0, rises_tot = 0, latch_tot = 0, oe_tot = 0, bad_tot = 0;
    initial begin
        for (int r = 0; r < 16; r++) rows[r] = '0;
        forever begin
            @(negedge clk);
            if (ser_clk && !pclk) begin
                sr = {sr[14:0], ser_data};
                rises_tot++;
                ones_tot += int'(ser_data);
            end
            pclk = ser_clk;
            if (ser_latch) begin
                latch_tot++;
                rows[row_addr] = sr;
            end
            if (!oe_n) oe_tot++;
            if (!oe_n && (ser_clk || ser_latch)) bad_tot++;
        end
    end

    int pass = 0, total = 0;
    int lbase = 0, tgt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic bit cond(input int c);
        case (c)
            0: return frame_done;
            1: return (latch_tot - lbase) >= tgt;
            default: return ser_clk;
        endcase
    endfunction

    task automatic wait_for(input int c, input string name);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            #1;
            if (cond(c)) return;
        end
        total++;
        $display("FAIL timeout %s: got no event, expected one within 20000 cycles", name);
    endtask

    typedef struct {
        string        name;
        logic [255:0] mat;
        int           row;
        logic [15:0]  bits;
        int           ones;
    } vec_t;

    vec_t vt [4];
    int ob, rb, lb, oeb, t0, c0;

    initial begin
        vt[0] = '{"pixel_3_5",  256'd1 << 53,          3,  16'h0020, 1};
        vt[1] = '{"full",       {256{1'b1}},           0,  16'hFFFF, 256};
        vt[2] = '{"row15_pat",  {16'hA5C3, 240'd0},    15, 16'hA5C3, 8};
        vt[3] = '{"pixel_0_0",  256'd1,                0,  16'h0001, 1};

        repeat (4) @(negedge clk);
        #1;
        chk("reset_outputs", 64'({ser_data, ser_clk, ser_latch, oe_n, row_addr, frame_done}), 64'h020);
        reset = 1'b1;
        c0 = cyc;
        wait_for(2, "first_rise");
        chk("first_rise_delay", 64'(cyc - c0), 64'd3);
        wait_for(0, "init_frame");
        chk("init_frame_ones", 64'(ones_tot), 64'd0);

        for (int i = 0; i < 4; i++) begin
            matrix = vt[i].mat;
            ob = ones_tot; rb = rises_tot; lb = latch_tot; oeb = oe_tot; t0 = cyc;
            wait_for(0, vt[i].name);
            chk({vt[i].name, "_row"}, 64'(rows[vt[i].row]), 64'(vt[i].bits));
            chk({vt[i].name, "_ones"}, 64'(ones_tot - ob), 64'(vt[i].ones));
            chk({vt[i].name, "_rises"}, 64'(rises_tot - rb), 64'd256);
            chk({vt[i].name, "_latches"}, 64'(latch_tot - lb), 64'd16);
            chk({vt[i].name, "_oe_low"}, 64'(oe_tot - oeb), 64'(OE_EXP));
            chk({vt[i].name, "_period"}, 64'(cyc - t0), 64'(FRAME));
        end

        matrix = '0;
        ob = ones_tot; lbase = latch_tot; tgt = 7;
        wait_for(1, "tear_row6_latch");
        wait_for(2, "tear_row7_shift");
        matrix = {256{1'b1}};
        wait_for(0, "tear_frame");
        chk("tear_cur_ones", 64'(ones_tot - ob), 64'd0);
        chk("tear_cur_row15", 64'(rows[15]), 64'd0);
        ob = ones_tot;
        wait_for(0, "tear_next");
        chk("tear_next_ones", 64'(ones_tot - ob), 64'd256);
        chk("tear_next_row7", 64'(rows[7]), 64'hFFFF);

        lbase = latch_tot; tgt = 9;
        wait_for(1, "abort_row8_latch");
        wait_for(2, "abort_row9_shift");
        repeat (5) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_outputs", 64'({ser_data, ser_clk, ser_latch, oe_n, row_addr, frame_done}), 64'h020);
        lb = latch_tot;
        repeat (3) @(negedge clk);
        #1;
        rb = rises_tot;
        reset = 1'b1;
        c0 = cyc;
        wait_for(2, "restart_rise");
        chk("restart_rise_delay", 64'(cyc - c0), 64'd3);
        chk("abort_no_latch", 64'(latch_tot - lb), 64'd0);
        lbase = latch_tot; tgt = 1;
        wait_for(1, "restart_latch");
        chk("restart_row_addr", 64'(row_addr), 64'd0);
        chk("restart_row0", 64'(rows[0]), 64'hFFFF);
        chk("restart_rises", 64'(rises_tot - rb), 64'd16);
        chk("no_blank_overlap", 64'(bad_tot), 64'd0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
